// File: rtl/alu_param_seq_if.sv
// Operand/result bus of alu_param_seq: start request and operand words in, result word stream out.
// master drives BEGIN/op_code/inbus; slave (the ALU) drives the result side.
interface alu_param_seq_if #(
    parameter int WIDTH = 8
);
    logic             BEGIN;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] inbus;
    logic [WIDTH-1:0] outbus;
    logic             out_valid;
    logic             END;
    logic             busy;
    logic             div_err;

    modport master (
        output BEGIN, op_code, inbus,
        input  outbus, out_valid, END, busy, div_err
    );

    modport slave (
        input  BEGIN, op_code, inbus,
        output outbus, out_valid, END, busy, div_err
    );
endinterface

// File: rtl/alu_param_seq.sv
// Sequential add/sub/radix-4 Booth mul/non-restoring div ALU; last word 4 (add/sub), 4+W/2 (mul), 6+W (div) cycles after BEGIN.
// No backpressure: result words stream on out_valid unconditionally; define ALU_PARAM_SEQ_DIV_EN to compile in the divider.
module alu_param_seq #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    alu_param_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = WIDTH + 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
`ifdef ALU_PARAM_SEQ_DIV_EN
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD1, ST_LOAD2, ST_LOAD3, ST_CALC, ST_CORR, ST_OUT1, ST_OUT2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] x_q, y_q, qr_q;
    logic [AW-1:0]    acc_q;
    logic             qm1_q;
    logic [CW-1:0]    cnt_q;

    // Booth recoding of {Q[1:0],Q[-1]} against the sign-extended multiplicand
    logic [AW-1:0] m_ext, booth_add, booth_sum;
    always_comb begin
        m_ext     = {{2{y_q[WIDTH-1]}}, y_q};
        booth_add = '0;
        case ({qr_q[1:0], qm1_q})
            3'b001, 3'b010: booth_add = m_ext;
            3'b011:         booth_add = m_ext << 1;
            3'b100:         booth_add = -(m_ext << 1);
            3'b101, 3'b110: booth_add = -m_ext;
            default:        booth_add = '0;
        endcase
        booth_sum = acc_q + booth_add;
    end

`ifdef ALU_PARAM_SEQ_DIV_EN
    logic [WIDTH-1:0] m_q;
    logic             err_q;
    logic             div_bad;
    logic [AW-1:0]    div_m, div_sh, div_step;
    always_comb begin
        div_bad  = (bus.inbus == '0) || (x_q >= bus.inbus);
        div_m    = {2'b00, m_q};
        div_sh   = {acc_q[AW-2:0], qr_q[WIDTH-1]};
        div_step = acc_q[AW-1] ? (div_sh + div_m) : (div_sh - div_m);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.BEGIN) begin
`ifdef ALU_PARAM_SEQ_DIV_EN
                    state_d = ST_LOAD1;
`else
                    state_d = (bus.op_code == OP_DIV) ? ST_OUT1 : ST_LOAD1;
`endif
                end
            end
            ST_LOAD1: state_d = ST_LOAD2;
            ST_LOAD2: begin
`ifdef ALU_PARAM_SEQ_DIV_EN
                state_d = (op_q == OP_DIV) ? ST_LOAD3 : ST_CALC;
`else
                state_d = ST_CALC;
`endif
            end
`ifdef ALU_PARAM_SEQ_DIV_EN
            ST_LOAD3: state_d = div_bad ? ST_OUT1 : ST_CALC;
            ST_CORR:  state_d = ST_OUT1;
`endif
            ST_CALC: begin
                case (op_q)
                    OP_MUL:  state_d = (cnt_q == MUL_LAST) ? ST_OUT1 : ST_CALC;
`ifdef ALU_PARAM_SEQ_DIV_EN
                    OP_DIV:  state_d = (cnt_q == DIV_LAST) ? ST_CORR : ST_CALC;
`endif
                    default: state_d = ST_OUT1;
                endcase
            end
            ST_OUT1: begin
                state_d = ((op_q == OP_MUL) || (op_q == OP_DIV)) ? ST_OUT2 : ST_IDLE;
`ifndef ALU_PARAM_SEQ_DIV_EN
                if (op_q == OP_DIV) state_d = ST_IDLE;
`endif
            end
            ST_OUT2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.outbus    = '0;
        bus.out_valid = 1'b0;
        bus.END       = 1'b0;
        bus.div_err   = 1'b0;
        bus.busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_OUT1: begin
                bus.out_valid = 1'b1;
                bus.outbus    = (op_q == OP_MUL) ? acc_q[WIDTH-1:0] : qr_q;
                bus.END       = (op_q == OP_ADD) || (op_q == OP_SUB);
`ifdef ALU_PARAM_SEQ_DIV_EN
                bus.div_err   = (op_q == OP_DIV) && err_q;
`else
                if (op_q == OP_DIV) begin
                    bus.outbus  = '0;
                    bus.END     = 1'b1;
                    bus.div_err = 1'b1;
                end
`endif
            end
            ST_OUT2: begin
                bus.out_valid = 1'b1;
                bus.END       = 1'b1;
                bus.outbus    = (op_q == OP_MUL) ? qr_q : acc_q[WIDTH-1:0];
`ifdef ALU_PARAM_SEQ_DIV_EN
                bus.div_err   = (op_q == OP_DIV) && err_q;
`endif
            end
            default: ;
        endcase
    end

    // Mul result sits in {acc[W-1:0], qr}; div quotient in qr, remainder in acc; add/sub result in qr.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            qr_q  <= '0;
            acc_q <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
`ifdef ALU_PARAM_SEQ_DIV_EN
            m_q   <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.BEGIN) begin
                        op_q  <= bus.op_code;
                        cnt_q <= '0;
                    end
                end
                ST_LOAD1: x_q <= bus.inbus;
                ST_LOAD2: begin
                    y_q   <= bus.inbus;
                    acc_q <= '0;
                    qr_q  <= x_q;
                    qm1_q <= 1'b0;
                end
`ifdef ALU_PARAM_SEQ_DIV_EN
                ST_LOAD3: begin
                    m_q   <= bus.inbus;
                    acc_q <= {2'b00, x_q};
                    err_q <= div_bad;
                    qr_q  <= div_bad ? '1 : y_q;
                end
                ST_CORR: begin
                    if (acc_q[AW-1]) acc_q <= acc_q + div_m;
                end
`endif
                ST_CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    case (op_q)
                        OP_ADD: qr_q <= x_q + y_q;
                        OP_SUB: qr_q <= x_q - y_q;
                        OP_MUL: begin
                            acc_q <= {{2{booth_sum[AW-1]}}, booth_sum[AW-1:2]};
                            qr_q  <= {booth_sum[1:0], qr_q[WIDTH-1:2]};
                            qm1_q <= qr_q[1];
                        end
                        default: begin
`ifdef ALU_PARAM_SEQ_DIV_EN
                            acc_q <= div_step;
                            qr_q  <= {qr_q[WIDTH-2:0], ~div_step[AW-1]};
`endif
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule
